// File: rtl/mdu_sched.sv
// Multiply/divide sequencer: owns HI/LO, models mult/div latency with a down-counter and
// raises the D-stage stall for MDU-class instructions that would collide with it.
module mdu_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        md_in_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ovr
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             ovr_q, ovr_d;

  logic             start_md;
  logic [63:0]      a_sx, b_sx;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      a_mag, b_mag, quot_m, rem_m;
  logic [31:0]      quot_s, rem_s, quot_u, rem_u;

  assign start_md = start && (op == OpMult || op == OpMultu || op == OpDiv || op == OpDivu);

  // Arithmetic works from the latched operands so the E-stage inputs may change freely.
  always_comb begin
    a_sx   = {{32{a_q[31]}}, a_q};
    b_sx   = {{32{b_q[31]}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
    quot_m = '0;
    rem_m  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (b_q != 32'd0) begin
      quot_m = a_mag / b_mag;
      rem_m  = a_mag % b_mag;
      quot_u = a_q / b_q;
      rem_u  = a_q % b_q;
    end
    // Signed divide via magnitudes: quotient truncates toward zero, remainder takes the
    // dividend's sign; -2^31 / -1 wraps to -2^31 with remainder 0.
    quot_s = (a_q[31] ^ b_q[31]) ? (~quot_m + 32'd1) : quot_m;
    rem_s  = a_q[31] ? (~rem_m + 32'd1) : rem_m;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          if (start_md) begin
            op_d    = op;
            a_d     = rs_val;
            b_d     = rt_val;
            cnt_d   = (op == OpMult || op == OpMultu) ? MultLoad : DivLoad;
            state_d = StRun;
          end else if (op == OpMthi) begin
            hi_d = rs_val;
          end else if (op == OpMtlo) begin
            lo_d = rs_val;
          end
        end
      end
      StRun: begin
        if (start) begin
          ovr_d = 1'b1;
        end
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntOne) begin
          state_d = StIdle;
          cnt_d   = '0;
          case (op_q)
            OpMult:  {hi_d, lo_d} = prod_s;
            OpMultu: {hi_d, lo_d} = prod_u;
            OpDiv: begin
              if (b_q != 32'd0) begin
                hi_d = rem_s;
                lo_d = quot_s;
              end
            end
            OpDivu: begin
              if (b_q != 32'd0) begin
                hi_d = rem_u;
                lo_d = quot_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign stall_md = md_in_D && (busy || start_md);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed vector table, hand-written corner sequences and
// randomized operations checked against a transaction-level arithmetic model.
module tb_mdu_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        md_in_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ovr;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural HI/LO as the bench believes them to be.
  logic [31:0] mhi, mlo;

  mdu_sched #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .cancel  (cancel),
    .md_in_D (md_in_D),
    .busy    (busy),
    .stall_md(stall_md),
    .hi      (hi),
    .lo      (lo),
    .ovr     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {hi,lo} after an operation, from plain 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = {h, l};
    case (o)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd4: if (b != 0) begin
        res = {32'(ua % ub), 32'(ua / ub)};
      end
      3'd5: res = {a, l};
      3'd6: res = {h, a};
      default: ;
    endcase
    return res;
  endfunction

  function automatic int cycles_of(input logic [2:0] o);
    return (o == 3'd1 || o == 3'd2) ? 5 : 10;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
  endtask

  // Counts busy cycles after the issuing edge; returns in the first cycle busy is low.
  task automatic wait_done(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      op     = 3'd0;
      cancel = 1'b0;
      #1;
      if (busy) n++;
      else break;
    end
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] v);
    @(posedge clk); #1;
    issue(o, v, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    op    = 3'd0;
    #1;
  endtask

  initial begin
    int n;
    int nstall;
    logic [63:0] r;
    logic [2:0] o;
    logic [31:0] a, b;

    reset = 1'b0; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
    cancel = 1'b0; md_in_D = 1'b0;
    mhi = '0; mlo = '0;

    vecs[0] = '{3'd1, 32'hFFFFFFFD, 32'd7, 32'hA0, 32'hB0, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'd2, 32'hA1, 32'hB1, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'hA2, 32'hB2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd4, 32'd7, 32'd0, 32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};
    vecs[4] = '{3'd4, 32'd100, 32'd7, 32'hA4, 32'hB4, 32'h00000002, 32'h0000000E, 10};
    vecs[5] = '{3'd1, 32'h80000000, 32'h80000000, 32'hA5, 32'hB5, 32'h40000000, 32'h0, 5};
    vecs[6] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'hA6, 32'hB6, 32'h0, 32'h80000000, 10};
    vecs[7] = '{3'd3, 32'd7, 32'hFFFFFFFE, 32'hA7, 32'hB7, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hA8, 32'hB8, 32'hFFFFFFFE, 32'h1, 5};

    #12;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_ovr", {31'b0, ovr}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      move_to(3'd5, vecs[i].pre_hi);
      move_to(3'd6, vecs[i].pre_lo);
      check($sformatf("vec%0d_pre_hi", i), hi, vecs[i].pre_hi);
      check($sformatf("vec%0d_pre_lo", i), lo, vecs[i].pre_lo);
      @(posedge clk); #1;
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      #1;
      check($sformatf("vec%0d_idle_at_start", i), {31'b0, busy}, 32'd0);
      wait_done(n);
      check($sformatf("vec%0d_cycles", i), n, vecs[i].cyc);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      mhi = vecs[i].exp_hi;
      mlo = vecs[i].exp_lo;
    end

    // Randomized operations, each issued in the first idle cycle after the previous one.
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      r = model(o, a, b, mhi, mlo);
      if (o == 3'd5 || o == 3'd6) begin
        move_to(o, a);
      end else begin
        issue(o, a, b);
        wait_done(n);
        check($sformatf("rnd%0d_cycles", i), n, cycles_of(o));
      end
      check($sformatf("rnd%0d_hi", i), hi, r[63:32]);
      check($sformatf("rnd%0d_lo", i), lo, r[31:0]);
      mhi = r[63:32];
      mlo = r[31:0];
    end

    // D-stage stall across a divide, plus a protocol-violating start mid-run.
    @(posedge clk); #1;
    md_in_D = 1'b1;
    issue(3'd5, 32'h1234, 32'h0);
    #1;
    check("stall_mthi_idle", {31'b0, stall_md}, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    #1;
    check("stall_start_cycle", {31'b0, stall_md}, 32'd1);
    nstall = 0;
    n = 0;
    for (int k = 1; k < 40; k++) begin
      @(posedge clk); #1;
      start  = (k == 3);
      op     = (k == 3) ? 3'd5 : 3'd0;
      rs_val = (k == 3) ? 32'hDEAD : 32'h0;
      #1;
      if (!busy) begin
        check("stall_falls", {31'b0, stall_md}, 32'd0);
        break;
      end
      n++;
      if (stall_md) nstall++;
    end
    check("stall_busy_cycles", n, 32'd10);
    check("stall_count", nstall, 32'd10);
    check("ovr_set", {31'b0, ovr}, 32'd1);
    check("ovr_hi", hi, 32'd2);
    check("ovr_lo", lo, 32'd14);
    md_in_D = 1'b0;
    mhi = 32'd2;
    mlo = 32'd14;

    // Cancel at busy cycle 2.
    @(posedge clk); #1;
    issue(3'd1, 32'd3, 32'd4);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check("cancel_busy1", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    #1;
    check("cancel_busy", {31'b0, busy}, 32'd0);
    check("cancel_hi", hi, mhi);
    check("cancel_lo", lo, mlo);
    @(posedge clk); #2;
    check("cancel_stays_idle", {31'b0, busy}, 32'd0);

    // Cancel beats a same-cycle start in IDLE.
    @(posedge clk); #1;
    issue(3'd1, 32'd3, 32'd4);
    cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cancel = 1'b0;
    #1;
    check("cancel_start_busy", {31'b0, busy}, 32'd0);

    // Back-to-back: the second start lands in the first idle cycle after completion.
    issue(3'd2, 32'd6, 32'd7);
    wait_done(n);
    check("b2b_first_lo", lo, 32'd42);
    issue(3'd1, 32'hFFFFFFFF, 32'd5);
    wait_done(n);
    check("b2b_second_cycles", n, 32'd5);
    check("b2b_second_hi", hi, 32'hFFFFFFFF);
    check("b2b_second_lo", lo, 32'hFFFFFFFB);

    // Asynchronous reset in the middle of a run.
    @(posedge clk); #1;
    issue(3'd1, 32'd9, 32'd9);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    check("rst_mid_ovr", {31'b0, ovr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #2;
    check("rst_after_busy", {31'b0, busy}, 32'd0);
    check("rst_after_lo", lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
